// File: rtl/note_playback_reader.sv
// Sweeps NoteStorage once per pass and publishes the set of notes sounding at a single time snapshot.
// Define PLAYBACK_LOOP_EN to restart the song, including a timer reset, whenever a sweep finds nothing pending.
module note_playback_reader #(
  parameter int MAXNOTEADDRESS = 100,
  parameter int TIMEBITS       = 29
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                startPlayback,
  input  logic                stopPlayback,
  input  logic [TIMEBITS-1:0] playbackTime,
  input  logic [61:0]         retrievedNoteData,
  output logic [6:0]          noteReadAddress,
  output logic [15:0]         activeNotes,
  output logic [15:0]         noteOnPulse,
  output logic                sweepDone,
  output logic                playbackFinished,
  output logic                resetTimerRequest
);

  typedef enum logic [2:0] {IDLE, START, SCANADDR, SCANWAIT, SCANEVAL, COMMIT} stateT;

`ifdef PLAYBACK_LOOP_EN
  localparam logic LoopEnable = 1'b1;
`else
  localparam logic LoopEnable = 1'b0;
`endif

  stateT               state, stateNext;
  logic [15:0]         shadow;
  logic                pendingSeen;
  logic [TIMEBITS-1:0] timeSnapshot;
  logic [3:0]          noteCode;
  logic [TIMEBITS-1:0] noteStart, noteEnd;
  logic                recordEmpty, noteSounding, notePending, lastAddress;

  assign noteCode     = retrievedNoteData[61:58];
  assign noteStart    = TIMEBITS'(retrievedNoteData[57:29]);
  assign noteEnd      = TIMEBITS'(retrievedNoteData[28:0]);
  assign recordEmpty  = (retrievedNoteData == '0);
  assign lastAddress  = (noteReadAddress == 7'(MAXNOTEADDRESS));
  // An end time of zero marks a note still held down, so it both sounds and keeps the song alive.
  assign noteSounding = (noteStart <= timeSnapshot) && ((noteEnd == '0) || (timeSnapshot < noteEnd));
  assign notePending  = (noteStart > timeSnapshot) || (noteEnd == '0) || (noteEnd > timeSnapshot);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (startPlayback) stateNext = START;
      START:    stateNext = SCANADDR;
      SCANADDR: stateNext = SCANWAIT;
      SCANWAIT: stateNext = SCANEVAL;
      SCANEVAL: stateNext = (recordEmpty || lastAddress) ? COMMIT : SCANADDR;
      COMMIT:   stateNext = (pendingSeen || LoopEnable) ? SCANADDR : IDLE;
      default:  stateNext = IDLE;
    endcase
    if (stopPlayback) stateNext = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      noteReadAddress   <= '0;
      activeNotes       <= '0;
      noteOnPulse       <= '0;
      sweepDone         <= 1'b0;
      playbackFinished  <= 1'b0;
      resetTimerRequest <= 1'b0;
      shadow            <= '0;
      pendingSeen       <= 1'b0;
      timeSnapshot      <= '0;
    end else begin
      noteOnPulse       <= '0;
      sweepDone         <= 1'b0;
      resetTimerRequest <= 1'b0;
      if (stopPlayback) begin
        activeNotes     <= '0;
        shadow          <= '0;
        pendingSeen     <= 1'b0;
        noteReadAddress <= '0;
      end else begin
        case (state)
          START: begin
            resetTimerRequest <= 1'b1;
            playbackFinished  <= 1'b0;
            shadow            <= '0;
            pendingSeen       <= 1'b0;
            noteReadAddress   <= '0;
          end
          SCANADDR: begin
            if (noteReadAddress == '0) timeSnapshot <= playbackTime;
          end
          SCANEVAL: begin
            if (!recordEmpty) begin
              if (noteSounding) shadow[noteCode] <= 1'b1;
              if (notePending)  pendingSeen      <= 1'b1;
            end
            if (!(recordEmpty || lastAddress)) noteReadAddress <= noteReadAddress + 7'd1;
          end
          COMMIT: begin
            activeNotes      <= shadow;
            noteOnPulse      <= shadow & ~activeNotes;
            sweepDone        <= 1'b1;
            playbackFinished <= ~pendingSeen;
            shadow           <= '0;
            pendingSeen      <= 1'b0;
            noteReadAddress  <= '0;
            if (LoopEnable && !pendingSeen) resetTimerRequest <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
